cache_ctrl: RTL and testbench

Miss-handling controller for the direct-mapped, 4-word-line, write-back data cache. It sits between the processor's memory port and the pair {cache array, banked main memory}. It is a single FSM that resolves hits in the request cycle. On a miss it writes back a dirty victim line, fills the new line from memory and replays the access. The processor sees `stall` until `done`.

---
 rtl/cache_ctrl_pkg.sv | 27 ++
 rtl/cache_ctrl_if.sv | 39 +++
 rtl/mem_rd_tracker.sv | 34 +++
 rtl/cache_ctrl.sv | 156 +++++++++++++++
 tb/tb_cache_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared widths, FSM state encoding and the address layout of the
// direct-mapped, 4-word-line write-back cache controller.
package cache_ctrl_pkg;
    localparam int TAG_W       = 5;
    localparam int IDX_W       = 8;
    localparam int OFF_W       = 3;
    localparam int WORDS       = 4;
    localparam int WSEL_W      = $clog2(WORDS);
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int MEM_LAT_DEF = 2;

    typedef enum logic [2:0] {IDLE, WB, RD, FILL, RETRY} state_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] off;
    } addr_t;

    // Halfword-aligned byte address of word w within a line.
    function automatic logic [ADDR_W-1:0] line_word_addr(input logic [TAG_W-1:0]  tag,
                                                         input logic [IDX_W-1:0]  idx,
                                                         input logic [WSEL_W-1:0] w);
        return {tag, idx, w, 1'b0};
    endfunction
endpackage

// File: rtl/cache_ctrl_if.sv
// Processor, cache-array and memory signals of the miss controller.
// The controller takes the slave view; the environment drives the master view.
interface cache_ctrl_if;
    import cache_ctrl_pkg::*;

    logic              rd, wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, rdata;
    logic              done, stall, cache_hit, err;

    logic              c_enable, c_comp, c_write, c_valid_in;
    logic [TAG_W-1:0]  c_tag_in, c_tag_out;
    logic [IDX_W-1:0]  c_index;
    logic [OFF_W-1:0]  c_offset;
    logic [DATA_W-1:0] c_data_in, c_data_out;
    logic              c_hit, c_dirty, c_valid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_wr, mem_rd, mem_stall;

    modport slave (
        input  rd, wr, addr, wdata,
        input  c_tag_out, c_data_out, c_hit, c_dirty, c_valid,
        input  mem_rdata, mem_stall,
        output rdata, done, stall, cache_hit, err,
        output c_enable, c_comp, c_write, c_valid_in, c_tag_in, c_index, c_offset, c_data_in,
        output mem_addr, mem_wdata, mem_wr, mem_rd
    );

    modport master (
        output rd, wr, addr, wdata,
        output c_tag_out, c_data_out, c_hit, c_dirty, c_valid,
        output mem_rdata, mem_stall,
        input  rdata, done, stall, cache_hit, err,
        input  c_enable, c_comp, c_write, c_valid_in, c_tag_in, c_index, c_offset, c_data_in,
        input  mem_addr, mem_wdata, mem_wr, mem_rd
    );
endinterface

// File: rtl/mem_rd_tracker.sv
// Delay line that pairs each accepted memory read with the cycle its data
// returns, so the fill path knows which line word mem_rdata belongs to.
module mem_rd_tracker
    import cache_ctrl_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_vld,
    input  logic [WSEL_W-1:0] push_word,
    output logic              out_vld,
    output logic [WSEL_W-1:0] out_word
);
    logic [MEM_LAT-1:0]             vld_pipe;
    logic [MEM_LAT-1:0][WSEL_W-1:0] word_pipe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            word_pipe <= '0;
        end else begin
            vld_pipe[0]  <= push_vld;
            word_pipe[0] <= push_word;
            for (int k = 1; k < MEM_LAT; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                word_pipe[k] <= word_pipe[k-1];
            end
        end
    end

    assign out_vld  = vld_pipe[MEM_LAT-1];
    assign out_word = word_pipe[MEM_LAT-1];
endmodule

// File: rtl/cache_ctrl.sv
// Miss-handling FSM: hits complete in the request cycle; misses write back a
// dirty victim, refill the line through the read tracker and replay the access.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    cache_ctrl_if.slave  bus
);
    state_e            state, nxt_state;
    logic [WSEL_W-1:0] cnt, nxt_cnt;
    addr_t             lat_addr, req;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_wr;
    logic              latch_en, push_vld, trk_vld, fill_we, req_one, req_err;
    logic [WSEL_W-1:0] trk_word;

    assign req     = addr_t'(bus.addr);
    assign req_one = bus.rd ^ bus.wr;
    assign req_err = (bus.rd & bus.wr) | (req_one & bus.addr[0]);
    assign fill_we = trk_vld & ((state == RD) | (state == FILL));

    mem_rd_tracker #(.MEM_LAT(MEM_LAT)) u_trk (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_vld  (push_vld),
        .push_word (cnt),
        .out_vld   (trk_vld),
        .out_word  (trk_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wr    <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            if (latch_en) begin
                lat_addr  <= req;
                lat_wdata <= bus.wdata;
                lat_wr    <= bus.wr;
            end
        end
    end

    always_comb begin
        nxt_state      = state;
        nxt_cnt        = cnt;
        latch_en       = 1'b0;
        push_vld       = 1'b0;
        bus.rdata      = '0;
        bus.done       = 1'b0;
        bus.cache_hit  = 1'b0;
        bus.err        = 1'b0;
        bus.stall      = (state != IDLE);
        bus.c_enable   = 1'b0;
        bus.c_comp     = 1'b0;
        bus.c_write    = 1'b0;
        bus.c_valid_in = 1'b0;
        bus.c_tag_in   = '0;
        bus.c_index    = '0;
        bus.c_offset   = '0;
        bus.c_data_in  = '0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_wr     = 1'b0;
        bus.mem_rd     = 1'b0;

        case (state)
            IDLE: begin
                if (req_err) begin
                    bus.done = 1'b1;
                    bus.err  = 1'b1;
                end else if (req_one) begin
                    bus.c_enable  = 1'b1;
                    bus.c_comp    = 1'b1;
                    bus.c_write   = bus.wr;
                    bus.c_tag_in  = req.tag;
                    bus.c_index   = req.idx;
                    bus.c_offset  = req.off;
                    bus.c_data_in = bus.wdata;
                    latch_en      = 1'b1;
                    if (bus.c_hit & bus.c_valid) begin
                        bus.done      = 1'b1;
                        bus.cache_hit = 1'b1;
                        bus.rdata     = bus.rd ? bus.c_data_out : '0;
                    end else begin
                        nxt_cnt   = '0;
                        nxt_state = (bus.c_valid & bus.c_dirty) ? WB : RD;
                    end
                end
            end
            WB: begin
                // Victim tag comes straight from the array read of this cycle.
                bus.c_enable  = 1'b1;
                bus.c_index   = lat_addr.idx;
                bus.c_offset  = {cnt, 1'b0};
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = line_word_addr(bus.c_tag_out, lat_addr.idx, cnt);
                bus.mem_wdata = bus.c_data_out;
                if (!bus.mem_stall) begin
                    nxt_cnt = cnt + 1'b1;
                    if (cnt == WSEL_W'(WORDS - 1)) nxt_state = RD;
                end
            end
            RD: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = line_word_addr(lat_addr.tag, lat_addr.idx, cnt);
                if (!bus.mem_stall) begin
                    push_vld = 1'b1;
                    nxt_cnt  = cnt + 1'b1;
                    if (cnt == WSEL_W'(WORDS - 1)) nxt_state = FILL;
                end
            end
            FILL: begin
                if (fill_we && trk_word == WSEL_W'(WORDS - 1)) nxt_state = RETRY;
            end
            RETRY: begin
                bus.c_enable  = 1'b1;
                bus.c_comp    = 1'b1;
                bus.c_write   = lat_wr;
                bus.c_tag_in  = lat_addr.tag;
                bus.c_index   = lat_addr.idx;
                bus.c_offset  = lat_addr.off;
                bus.c_data_in = lat_wdata;
                bus.done      = 1'b1;
                bus.rdata     = lat_wr ? '0 : bus.c_data_out;
                bus.err       = ~bus.c_hit;
                nxt_state     = IDLE;
            end
            default: begin
                bus.done  = 1'b1;
                bus.err   = 1'b1;
                nxt_state = IDLE;
            end
        endcase

        // Returning read data owns the cache port; RD leaves it idle otherwise.
        if (fill_we) begin
            bus.c_enable   = 1'b1;
            bus.c_comp     = 1'b0;
            bus.c_write    = 1'b1;
            bus.c_valid_in = 1'b1;
            bus.c_tag_in   = lat_addr.tag;
            bus.c_index    = lat_addr.idx;
            bus.c_offset   = {trk_word, 1'b0};
            bus.c_data_in  = bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cache array and fixed-latency memory,
// with a queue of expected memory transactions checked as they are accepted.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    localparam int LAT = 2;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
    } memop_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    memop_t exp_q[$];

    cache_ctrl_if bus();

    cache_ctrl #(.MEM_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Cache array model
    bit        valid_a [256];
    bit        dirty_a [256];
    bit [4:0]  tag_a   [256];
    bit [15:0] data_a  [256][4];

    assign bus.c_tag_out  = tag_a[bus.c_index];
    assign bus.c_valid    = valid_a[bus.c_index];
    assign bus.c_dirty    = dirty_a[bus.c_index];
    assign bus.c_data_out = data_a[bus.c_index][bus.c_offset[2:1]];
    assign bus.c_hit      = valid_a[bus.c_index] && (tag_a[bus.c_index] == bus.c_tag_in);

    always @(posedge clk) begin
        if (bus.c_enable && bus.c_write) begin
            if (!bus.c_comp) begin
                tag_a[bus.c_index]                       <= bus.c_tag_in;
                valid_a[bus.c_index]                     <= bus.c_valid_in;
                dirty_a[bus.c_index]                     <= 1'b0;
                data_a[bus.c_index][bus.c_offset[2:1]]   <= bus.c_data_in;
            end else if (bus.c_hit) begin
                dirty_a[bus.c_index]                     <= 1'b1;
                data_a[bus.c_index][bus.c_offset[2:1]]   <= bus.c_data_in;
            end
        end
    end

    // Memory model: unwritten words hold pat(addr)
    function automatic logic [15:0] pat(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    bit [15:0]   mem_a [32768];
    bit          mem_w [32768];
    bit [LAT-1:0] rp_v;
    logic [15:0] rp_a [LAT];

    always @(posedge clk) begin
        if (bus.mem_wr && !bus.mem_stall) begin
            mem_a[bus.mem_addr[15:1]] <= bus.mem_wdata;
            mem_w[bus.mem_addr[15:1]] <= 1'b1;
        end
        rp_v[0] <= bus.mem_rd && !bus.mem_stall;
        rp_a[0] <= bus.mem_addr;
        for (int k = 1; k < LAT; k++) begin
            rp_v[k] <= rp_v[k-1];
            rp_a[k] <= rp_a[k-1];
        end
    end

    assign bus.mem_rdata = !rp_v[LAT-1] ? 16'h0 :
                           mem_w[rp_a[LAT-1][15:1]] ? mem_a[rp_a[LAT-1][15:1]] :
                           pat({rp_a[LAT-1][15:1], 1'b0});

    logic [89:0] all_out;
    assign all_out = {bus.rdata, bus.done, bus.stall, bus.cache_hit, bus.err,
                      bus.c_enable, bus.c_comp, bus.c_write, bus.c_valid_in, bus.c_tag_in,
                      bus.c_index, bus.c_offset, bus.c_data_in, bus.mem_addr, bus.mem_wdata,
                      bus.mem_wr, bus.mem_rd};

    function automatic logic [70:0] line_state(input logic [7:0] i);
        return {valid_a[i], dirty_a[i], tag_a[i], data_a[i][3], data_a[i][2], data_a[i][1], data_a[i][0]};
    endfunction

    task automatic push_reads(input logic [15:0] base);
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, base + 16'(2 * i), 16'h0});
    endtask

    task automatic push_write(input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back('{1'b1, a, d});
    endtask

    // Drives one request and scores accepted memory traffic cycle by cycle.
    task automatic do_req(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d,
                          input int s0, input int sl, input int rst_at,
                          output int lat, output logic [15:0] rdat, output logic hit,
                          output logic e, output int fills, output int ops);
        memop_t x;
        lat = -1; rdat = 'x; hit = 'x; e = 'x; fills = 0; ops = 0;
        @(negedge clk);
        bus.rd = r; bus.wr = w; bus.addr = a; bus.wdata = d;
        for (int c = 0; c < 60; c++) begin
            bus.mem_stall = (c >= s0) && (c < s0 + sl);
            #1;
            if (bus.c_enable && bus.c_write && !bus.c_comp) fills++;
            if ((bus.mem_rd || bus.mem_wr) && !bus.mem_stall) begin
                ops++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL memop_extra: got wr=%0b addr=%h data=%h, want none", bus.mem_wr, bus.mem_addr, bus.mem_wdata);
                end else begin
                    x = exp_q.pop_front();
                    if (bus.mem_wr !== x.wr || bus.mem_rd !== !x.wr || bus.mem_addr !== x.addr ||
                        (x.wr && bus.mem_wdata !== x.data)) begin
                        n_bad++;
                        $display("FAIL memop: got wr=%0b addr=%h data=%h, want wr=%0b addr=%h data=%h",
                                 bus.mem_wr, bus.mem_addr, bus.mem_wdata, x.wr, x.addr, x.data);
                    end
                end
            end
            if (c == rst_at) begin
                rst_n = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
                break;
            end
            if (bus.done) begin
                lat = c; rdat = bus.rdata; hit = bus.cache_hit; e = bus.err;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.mem_stall = 1'b0;
    endtask

    int lat, fills, ops;
    logic [15:0] rdat;
    logic hit, e;

    task automatic test_reset;
        rst_n = 1'b0;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0; bus.mem_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_outs: got %h want 0", all_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cold_read;
        push_reads(16'h1230);
        do_req(1, 0, 16'h1234, 16'h0, -1, 0, -1, lat, rdat, hit, e, fills, ops);
        n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL cold_lat: got %0d want 7", lat); end
        n_cmp++; if (hit !== 1'b0 || e !== 1'b0) begin n_bad++; $display("FAIL cold_flags: got hit=%b err=%b want 0/0", hit, e); end
        n_cmp++; if (rdat !== pat(16'h1234)) begin n_bad++; $display("FAIL cold_data: got %h want %h", rdat, pat(16'h1234)); end
        n_cmp++; if (fills !== 4 || exp_q.size() != 0) begin n_bad++; $display("FAIL cold_fills: got fills=%0d left=%0d want 4/0", fills, exp_q.size()); end
        do_req(1, 0, 16'h1234, 16'h0, -1, 0, -1, lat, rdat, hit, e, fills, ops);
        n_cmp++; if (lat !== 0 || hit !== 1'b1 || ops !== 0) begin n_bad++; $display("FAIL rehit: got lat=%0d hit=%b ops=%0d want 0/1/0", lat, hit, ops); end
        n_cmp++; if (rdat !== pat(16'h1234)) begin n_bad++; $display("FAIL rehit_data: got %h want %h", rdat, pat(16'h1234)); end
    endtask

    task automatic test_dirty_miss;
        do_req(0, 1, 16'h1234, 16'hBEEF, -1, 0, -1, lat, rdat, hit, e, fills, ops);
        n_cmp++; if (lat !== 0 || hit !== 1'b1 || e !== 1'b0) begin n_bad++; $display("FAIL store_hit: got lat=%0d hit=%b err=%b want 0/1/0", lat, hit, e); end
        push_write(16'h1230, pat(16'h1230));
        push_write(16'h1232, pat(16'h1232));
        push_write(16'h1234, 16'hBEEF);
        push_write(16'h1236, pat(16'h1236));
        push_reads(16'h9230);
        do_req(1, 0, 16'h9234, 16'h0, -1, 0, -1, lat, rdat, hit, e, fills, ops);
        n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL dirty_lat: got %0d want 11", lat); end
        n_cmp++; if (hit !== 1'b0 || e !== 1'b0) begin n_bad++; $display("FAIL dirty_flags: got hit=%b err=%b want 0/0", hit, e); end
        n_cmp++; if (rdat !== pat(16'h9234)) begin n_bad++; $display("FAIL dirty_data: got %h want %h", rdat, pat(16'h9234)); end
        n_cmp++; if (ops !== 8 || exp_q.size() != 0) begin n_bad++; $display("FAIL dirty_ops: got ops=%0d left=%0d want 8/0", ops, exp_q.size()); end
    endtask

    task automatic test_mem_stall;
        push_reads(16'h0150);
        do_req(1, 0, 16'h0154, 16'h0, 2, 3, -1, lat, rdat, hit, e, fills, ops);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL stall_lat: got %0d want 10", lat); end
        n_cmp++; if (fills !== 4 || exp_q.size() != 0) begin n_bad++; $display("FAIL stall_fills: got fills=%0d left=%0d want 4/0", fills, exp_q.size()); end
        n_cmp++; if (rdat !== pat(16'h0154) || hit !== 1'b0) begin n_bad++; $display("FAIL stall_data: got %h hit=%b want %h hit=0", rdat, hit, pat(16'h0154)); end
    endtask

    task automatic test_err;
        bit          er [3];
        bit          ew [3];
        logic [15:0] ea [3];
        logic [70:0] snap;
        er = '{1'b1, 1'b0, 1'b1};
        ew = '{1'b0, 1'b1, 1'b1};
        ea = '{16'h0003, 16'h9235, 16'h9234};
        for (int t = 0; t < 3; t++) begin
            snap = line_state(ea[t][10:3]);
            do_req(er[t], ew[t], ea[t], 16'h2222, -1, 0, -1, lat, rdat, hit, e, fills, ops);
            n_cmp++; if (lat !== 0 || e !== 1'b1 || hit !== 1'b0) begin n_bad++; $display("FAIL err_resp[%0d]: got lat=%0d err=%b hit=%b want 0/1/0", t, lat, e, hit); end
            n_cmp++; if (ops !== 0 || fills !== 0) begin n_bad++; $display("FAIL err_traffic[%0d]: got ops=%0d fills=%0d want 0/0", t, ops, fills); end
            n_cmp++; if (line_state(ea[t][10:3]) !== snap) begin n_bad++; $display("FAIL err_line[%0d]: got %h want %h", t, line_state(ea[t][10:3]), snap); end
        end
    endtask

    task automatic test_reset_mid_fill;
        int busy;
        push_reads(16'h5678);
        do_req(1, 0, 16'h567A, 16'h0, -1, 0, 5, lat, rdat, hit, e, fills, ops);
        n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL rst_fill_outs: got %h want 0", all_out); end
        n_cmp++; if (lat !== -1 || exp_q.size() != 0) begin n_bad++; $display("FAIL rst_fill_pre: got lat=%0d left=%0d want -1/0", lat, exp_q.size()); end
        rst_n = 1'b1;
        busy = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (bus.c_enable || bus.mem_rd || bus.mem_wr || bus.done || bus.stall) busy++;
        end
        n_cmp++; if (busy !== 0) begin n_bad++; $display("FAIL rst_fill_quiet: got %0d active cycles want 0", busy); end
        push_reads(16'h2468);
        do_req(1, 0, 16'h246A, 16'h0, -1, 0, -1, lat, rdat, hit, e, fills, ops);
        n_cmp++; if (lat !== 7 || hit !== 1'b0 || e !== 1'b0) begin n_bad++; $display("FAIL post_rst: got lat=%0d hit=%b err=%b want 7/0/0", lat, hit, e); end
        n_cmp++; if (rdat !== pat(16'h246A)) begin n_bad++; $display("FAIL post_rst_data: got %h want %h", rdat, pat(16'h246A)); end
    endtask

    task automatic test_store_miss;
        push_reads(16'h4000);
        do_req(0, 1, 16'h4000, 16'hC0DE, -1, 0, -1, lat, rdat, hit, e, fills, ops);
        n_cmp++; if (lat !== 7 || hit !== 1'b0 || e !== 1'b0) begin n_bad++; $display("FAIL stmiss: got lat=%0d hit=%b err=%b want 7/0/0", lat, hit, e); end
        do_req(1, 0, 16'h4000, 16'h0, -1, 0, -1, lat, rdat, hit, e, fills, ops);
        n_cmp++; if (lat !== 0 || hit !== 1'b1 || rdat !== 16'hC0DE) begin n_bad++; $display("FAIL stmiss_rd: got lat=%0d hit=%b data=%h want 0/1/c0de", lat, hit, rdat); end
        push_write(16'h4000, 16'hC0DE);
        push_write(16'h4002, pat(16'h4002));
        push_write(16'h4004, pat(16'h4004));
        push_write(16'h4006, pat(16'h4006));
        push_reads(16'h0800);
        do_req(1, 0, 16'h0802, 16'h0, -1, 0, -1, lat, rdat, hit, e, fills, ops);
        n_cmp++; if (lat !== 11 || rdat !== pat(16'h0802)) begin n_bad++; $display("FAIL evict: got lat=%0d data=%h want 11/%h", lat, rdat, pat(16'h0802)); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL evict_ops: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        do_req(1, 0, 16'h0802, 16'h0, -1, 0, -1, lat, rdat, hit, e, fills, ops);
        n_cmp++; if (lat !== 0 || hit !== 1'b1 || rdat !== pat(16'h0802)) begin n_bad++; $display("FAIL b2b_a: got lat=%0d hit=%b data=%h", lat, hit, rdat); end
        do_req(1, 0, 16'h9236, 16'h0, -1, 0, -1, lat, rdat, hit, e, fills, ops);
        n_cmp++; if (lat !== 0 || hit !== 1'b1 || rdat !== pat(16'h9236)) begin n_bad++; $display("FAIL b2b_b: got lat=%0d hit=%b data=%h", lat, hit, rdat); end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_dirty_miss();
        test_mem_stall();
        test_err();
        test_reset_mid_fill();
        test_store_miss();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
